// File: rtl/mux32_share_arbiter.sv
// mux32_share_arbiter: two-requester arbiter and sequencer for the shared 2:1 word mux.
// The mux select comes straight from the registered grant state, so it cannot glitch.
// The selected word is registered into a valid/ready output stage.
// Optional feature: define MUX32_ARB_RR_EN for round-robin tie-break; default is fixed
// priority with requester 0 winning every tie.
module mux32_share_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    // requester 0
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             last0,
    output logic             ready0,
    // requester 1
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             last1,
    output logic             ready1,
    // shared mux select
    output logic             slct,
    // output stage
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             busy
);

    // Smallest counter that can represent MAX_BURST.
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic            out_src_q, out_src_d;

`ifdef MUX32_ARB_RR_EN
    // Last granted requester; the other one wins the next tie.
    logic            ptr_q, ptr_d;
`endif

    logic            space;
    logic            xfer;
    logic [WIDTH-1:0] mux_word;
    logic [CntW-1:0] cnt_inc;
    logic            rel;
    logic            arb_req0;
    logic            arb_req1;
    logic            tie_grant1;

    // Handshake and mux: readys only in the matching grant state with room downstream.
    always_comb begin
        space    = !out_valid_q || out_ready;
        ready0   = (state_q == StGrant0) && req0 && space;
        ready1   = (state_q == StGrant1) && req1 && space;
        xfer     = ready0 || ready1;
        slct     = (state_q == StGrant1);
        mux_word = slct ? data1 : data0;
        cnt_inc  = cnt_q + CntW'(1);
    end

    // Tie-break decision between two simultaneous requests.
    always_comb begin
`ifdef MUX32_ARB_RR_EN
        tie_grant1 = !ptr_q;
`else
        tie_grant1 = 1'b0;
`endif
    end

    // Grant FSM next state, burst counter and release/re-arbitration.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rel      = 1'b0;
        arb_req0 = req0;
        arb_req1 = req1;
`ifdef MUX32_ARB_RR_EN
        ptr_d    = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                rel = 1'b1;
            end
            StGrant0: begin
                if (!req0) begin
                    rel = 1'b1;
                end else if (ready0) begin
                    if (last0) begin
                        // The burst just ended; its still-high req belongs to that beat.
                        rel      = 1'b1;
                        arb_req0 = 1'b0;
                    end else if (cnt_inc == MaxCnt) begin
                        rel = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StGrant1: begin
                if (!req1) begin
                    rel = 1'b1;
                end else if (ready1) begin
                    if (last1) begin
                        rel      = 1'b1;
                        arb_req1 = 1'b0;
                    end else if (cnt_inc == MaxCnt) begin
                        rel = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                rel = 1'b1;
            end
        endcase

        // Re-arbitrate in the same cycle as the release so there is no bubble.
        if (rel) begin
            cnt_d = '0;
            if (arb_req0 && arb_req1) begin
                state_d = tie_grant1 ? StGrant1 : StGrant0;
            end else if (arb_req0) begin
                state_d = StGrant0;
            end else if (arb_req1) begin
                state_d = StGrant1;
            end else begin
                state_d = StIdle;
            end
`ifdef MUX32_ARB_RR_EN
            if (state_d == StGrant0) begin
                ptr_d = 1'b0;
            end else if (state_d == StGrant1) begin
                ptr_d = 1'b1;
            end
`endif
        end
    end

    // Output stage: capture on a transfer, drain when the consumer takes the word.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_word;
            out_src_d   = ready1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any held word immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

`ifdef MUX32_ARB_RR_EN
    // Pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Drive the registered outputs.
    always_comb begin
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_src   = out_src_q;
        busy      = (state_q != StIdle);
    end

    // Invariants of the grant and output stage.
    a_ready_onehot : assert property (@(posedge clk) disable iff (!reset_n)
        !(ready0 && ready1));
    a_cnt_below_max : assert property (@(posedge clk) disable iff (!reset_n)
        cnt_q < MaxCnt);
    a_hold_on_stall : assert property (@(posedge clk) disable iff (!reset_n)
        (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q)
                                         && $stable(out_src_q)));

endmodule

// File: tb/tb_mux32_share_arbiter.sv
// Directed self-checking bench for mux32_share_arbiter (WIDTH=32, MAX_BURST=4).
// Expected orders follow MUX32_ARB_RR_EN the same way the design does.
module tb_mux32_share_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0, req1, last0, last1;
    logic [31:0] data0, data1;
    logic        ready0, ready1;
    logic        slct, out_valid, out_src, out_ready, busy;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    mux32_share_arbiter #(
        .WIDTH    (32),
        .MAX_BURST(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req0),
        .data0    (data0),
        .last0    (last0),
        .ready0   (ready0),
        .req1     (req1),
        .data1    (data1),
        .last1    (last1),
        .ready1   (ready1),
        .slct     (slct),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; data0 = '0; last0 = 1'b0;
        req1 = 1'b0; data1 = '0; last1 = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Streams n0/n1 beats (last on the final one), optionally stalling the consumer.
    // exp_src bit k is the requester expected for accepted beat k.
    task automatic run_stream(input string tag, input int n0, input int n1,
                              input int stall_at, input int stall_len,
                              input logic [11:0] exp_src, input int exp_last);
        int i0 = 0;
        int i1 = 0;
        int n = 0;
        int first = -1;
        int last = -1;
        logic mv = 1'b0;
        logic [31:0] md = '0;
        logic ms = 1'b0;
        logic a0, a1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            req0  = (i0 < n0);
            data0 = 32'hA000_0000 | 32'(i0);
            last0 = (i0 == n0 - 1);
            req1  = (i1 < n1);
            data1 = 32'hB000_0000 | 32'(i1);
            last1 = (i1 == n1 - 1);
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            check1({tag, "_out_valid"}, out_valid, mv);
            if (mv) begin
                check32({tag, "_out_data"}, out_data, md);
                check1({tag, "_out_src"}, out_src, ms);
            end
            if (mv && !out_ready) begin
                check1({tag, "_stall_ready"}, ready0 | ready1, 1'b0);
            end
            a0 = ready0;
            a1 = ready1;
            if (a0 || a1) begin
                if (n < 12) check1({tag, "_src_order"}, a1, exp_src[n]);
                md = a1 ? data1 : data0;
                ms = a1;
                mv = 1'b1;
                if (first < 0) first = cyc;
                last = cyc;
                n++;
                if (a1) i1++;
                else i0++;
            end else if (out_ready) begin
                mv = 1'b0;
            end
            tick();
            if (i0 == n0 && i1 == n1 && !mv) break;
        end
        check_int({tag, "_beats"}, n, n0 + n1);
        check_int({tag, "_first_accept"}, first, 1);
        check_int({tag, "_last_accept"}, last, exp_last);
        idle_inputs();
        check1({tag, "_idle_after"}, busy, 1'b0);
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        #2;
        // Asynchronous reset values, before any clock edge.
        check1("rst_busy", busy, 1'b0);
        check1("rst_slct", slct, 1'b0);
        check1("rst_ready0", ready0, 1'b0);
        check1("rst_ready1", ready1, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check32("rst_out_data", out_data, 32'h0);
        check1("rst_out_src", out_src, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single-beat burst from requester 0.
        req0 = 1'b1; data0 = 32'hA5A5_0001; last0 = 1'b1;
        #1;
        check1("t1_c0_ready0", ready0, 1'b0);
        check1("t1_c0_busy", busy, 1'b0);
        tick();
        check1("t1_c1_busy", busy, 1'b1);
        check1("t1_c1_slct", slct, 1'b0);
        check1("t1_c1_ready0", ready0, 1'b1);
        tick();
        req0 = 1'b0; last0 = 1'b0;
        #1;
        check1("t1_c2_out_valid", out_valid, 1'b1);
        check32("t1_c2_out_data", out_data, 32'hA5A5_0001);
        check1("t1_c2_out_src", out_src, 1'b0);
        check1("t1_c2_busy", busy, 1'b0);
        tick();
        check1("t1_c3_out_valid", out_valid, 1'b0);

        // Both stream 6 beats from IDLE, MAX_BURST=4.
        do_reset();
`ifdef MUX32_ARB_RR_EN
        run_stream("t2", 6, 6, 100, 0, 12'hCF0, 12);
`else
        run_stream("t2", 6, 6, 100, 0, 12'hFC0, 12);
`endif

        // Consumer stall for 3 cycles in the middle of a burst.
        do_reset();
        run_stream("t3", 6, 0, 3, 3, 12'h000, 9);

        // Requester 1 drops req after 2 beats without last while req0 waits.
        do_reset();
        req1 = 1'b1; data1 = 32'hD000_0001;
        tick();
        check1("t4_c1_slct", slct, 1'b1);
        check1("t4_c1_ready1", ready1, 1'b1);
        tick();
        data1 = 32'hD000_0002;
        req0 = 1'b1; data0 = 32'hE000_0000; last0 = 1'b1;
        #1;
        check1("t4_c2_slct", slct, 1'b1);
        check1("t4_c2_ready1", ready1, 1'b1);
        check1("t4_c2_ready0", ready0, 1'b0);
        tick();
        req1 = 1'b0;
        #1;
        check1("t4_c3_slct", slct, 1'b1);
        check1("t4_c3_ready1", ready1, 1'b0);
        check1("t4_c3_ready0", ready0, 1'b0);
        check32("t4_c3_out_data", out_data, 32'hD000_0002);
        tick();
        check1("t4_c4_slct", slct, 1'b0);
        check1("t4_c4_ready0", ready0, 1'b1);
        check1("t4_c4_out_valid", out_valid, 1'b0);
        tick();
        req0 = 1'b0; last0 = 1'b0;
        #1;
        check32("t4_c5_out_data", out_data, 32'hE000_0000);
        check1("t4_c5_out_src", out_src, 1'b0);
        tick();
        check1("t4_c6_busy", busy, 1'b0);

        // Reset pulse during beat 2 of a requester 1 burst.
        do_reset();
        req1 = 1'b1; data1 = 32'hF000_0001;
        tick();
        check1("t5_c1_ready1", ready1, 1'b1);
        tick();
        data1 = 32'hF000_0002;
        #1;
        check1("t5_c2_out_valid", out_valid, 1'b1);
        check1("t5_c2_slct", slct, 1'b1);
        reset_n = 1'b0;
        #1;
        check1("t5_rst_out_valid", out_valid, 1'b0);
        check1("t5_rst_slct", slct, 1'b0);
        check1("t5_rst_busy", busy, 1'b0);
        check32("t5_rst_out_data", out_data, 32'h0);
        #2;
        reset_n = 1'b1;
        req1 = 1'b0;
        tick();
        check1("t5_post_busy", busy, 1'b0);
        check1("t5_post_out_valid", out_valid, 1'b0);
        // First tie after reset goes to requester 0.
        req0 = 1'b1; data0 = 32'h1111_0000; last0 = 1'b1;
        req1 = 1'b1; data1 = 32'h2222_0000; last1 = 1'b1;
        tick();
        check1("t5_tie_slct", slct, 1'b0);
        check1("t5_tie_ready0", ready0, 1'b1);
        check1("t5_tie_ready1", ready1, 1'b0);
        tick();
        // Release with last while req1 waits: requester 1 granted at the same edge.
        req0 = 1'b0; last0 = 1'b0;
        #1;
        check1("t5_sw_slct", slct, 1'b1);
        check1("t5_sw_ready1", ready1, 1'b1);
        check32("t5_sw_out_data", out_data, 32'h1111_0000);
        tick();
        req1 = 1'b0; last1 = 1'b0;
        #1;
        check32("t5_end_out_data", out_data, 32'h2222_0000);
        check1("t5_end_out_src", out_src, 1'b1);
        tick();
        check1("t5_end_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
